// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources, with burst lock.
// Latency: grant one cycle after req_valid; tx_* are combinational from the grant; one IDLE bubble per release.
// Backpressure: tx_ready passes straight to the owner's req_ready; the grant is held while tx_valid & !tx_ready.
// Optional feature macro: UART_ARB_STATS_EN adds per-requester saturating byte counters on stat_bytes_o.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_lock_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o,
  input  logic                   stat_clr_i,
  output logic [16*NUM_REQ-1:0]  stat_bytes_o
);

  localparam int              PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]      BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] last_ptr_q, last_ptr_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;

  logic             win_hi_found;
  logic [PTR_W-1:0] win_hi_idx;
  logic [PTR_W-1:0] win_lo_idx;
  logic [PTR_W-1:0] win_idx;

  logic             owner_valid;
  logic             owner_lock;
  logic             xfer;

  // Round-robin search: lowest valid index above last_ptr, otherwise wrap to the lowest valid index.
  always_comb begin
    win_hi_found = 1'b0;
    win_hi_idx   = '0;
    win_lo_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        win_lo_idx = PTR_W'(k);
        if (PTR_W'(k) > last_ptr_q) begin
          win_hi_found = 1'b1;
          win_hi_idx   = PTR_W'(k);
        end
      end
    end
    win_idx = win_hi_found ? win_hi_idx : win_lo_idx;
  end

  // Owner datapath: route the owner's byte to the UART and the UART's ready back to the owner only.
  always_comb begin
    grant_o     = '0;
    req_ready_o = '0;
    tx_data_o   = '0;
    tx_valid_o  = 1'b0;
    busy_o      = 1'b0;
    owner_valid = 1'b0;
    owner_lock  = 1'b0;
    if (state_q == ST_OWNED) begin
      busy_o = 1'b1;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (owner_q == PTR_W'(k)) begin
          grant_o[k]     = 1'b1;
          req_ready_o[k] = tx_ready_i;
          tx_data_o      = req_data_i[8*k +: 8];
          owner_valid    = req_valid_i[k];
          owner_lock     = req_lock_i[k];
        end
      end
      tx_valid_o = owner_valid;
    end
  end

  assign xfer = tx_valid_o & tx_ready_i;

  // Next-state: grant on any request, hold through locked bursts up to MAX_BURST bytes, release otherwise.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_ptr_d  = last_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) begin
          state_d     = ST_OWNED;
          owner_d     = win_idx;
          burst_cnt_d = '0;
        end
      end
      ST_OWNED: begin
        if (xfer) begin
          if (owner_lock && (burst_cnt_q < BURST_LAST)) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end else begin
            state_d     = ST_IDLE;
            last_ptr_d  = owner_q;
            burst_cnt_d = '0;
          end
        end else if (!owner_valid && !owner_lock) begin
          // Owner dropped its request without asking to keep the line: give it up.
          state_d     = ST_IDLE;
          last_ptr_d  = owner_q;
          burst_cnt_d = '0;
        end
        // Invalid but locked owner keeps the grant indefinitely.
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset puts last_ptr on the highest index so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      last_ptr_q  <= PTR_LAST;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_ptr_q  <= last_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef UART_ARB_STATS_EN
  logic [15:0] stat_q [NUM_REQ];
  logic [15:0] stat_d [NUM_REQ];

  // Counter update: clear beats a simultaneous transfer; counts stick at all-ones.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_d[i] = stat_q[i];
      if (stat_clr_i) begin
        stat_d[i] = '0;
      end else if (xfer && (owner_q == PTR_W'(i)) && (stat_q[i] != 16'hFFFF)) begin
        stat_d[i] = stat_q[i] + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_q[i] <= stat_d[i];
      end
    end
  end

  // Flatten counters onto the output bus, requester i at bits [16i+15:16i].
  always_comb begin
    stat_bytes_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_bytes_o[16*i +: 16] = stat_q[i];
    end
  end
`else
  logic unused_stat_clr;

  assign unused_stat_clr = stat_clr_i;
  assign stat_bytes_o    = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte-source models feed the DUT, a monitor scores each UART handshake.
// Expected transfers (source, byte, cycles since previous transfer) are queued when stimulus is issued.
// Direct checks cover reset values, grant latency, stall stability, async reset and statistics.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_lock;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  grant;
  logic        busy;
  logic        stat_clr;
  logic [31:0] stat_bytes;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(2), .MAX_BURST(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_lock_i   (req_lock),
    .req_ready_o  (req_ready),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .grant_o      (grant),
    .busy_o       (busy),
    .stat_clr_i   (stat_clr),
    .stat_bytes_o (stat_bytes)
  );

  typedef struct {
    int         src;
    logic [7:0] dat;
    int         gap;   // -1: do not check spacing
  } exp_t;

  exp_t       expq[$];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [1:0] lock_mode;
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_xfer = 0;
  int         xfer_cnt = 0;
  logic       fire0, fire1;
  exp_t       mon_e;
  int         mon_src;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic exp_push(input int s, input logic [7:0] d, input int g);
    exp_t e;
    e.src = s;
    e.dat = d;
    e.gap = g;
    expq.push_back(e);
  endtask

  function automatic void drive_inputs();
    req_valid[0]  = (q0.size() > 0);
    req_data[7:0] = (q0.size() > 0) ? q0[0] : 8'h00;
    req_lock[0]   = lock_mode[0] && (q0.size() > 1);
    req_valid[1]  = (q1.size() > 0);
    req_data[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
    req_lock[1]   = lock_mode[1] && (q1.size() > 1);
  endfunction

  // Source models: a byte leaves its queue once it has been handshaken.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_lock  = '0;
    forever begin
      @(negedge clk);
      fire0 = req_valid[0] & req_ready[0];
      fire1 = req_valid[1] & req_ready[1];
      @(posedge clk);
      #1;
      if (fire0 && q0.size() > 0) void'(q0.pop_front());
      if (fire1 && q1.size() > 0) void'(q1.pop_front());
      drive_inputs();
    end
  end

  // Monitor: every UART handshake is scored against the head of the expectation queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx_valid && tx_ready) begin
        xfer_cnt++;
        mon_src = (grant == 2'b01) ? 0 : (grant == 2'b10) ? 1 : 9;
        n_vec++;
        if (expq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_xfer: got src %0d data %02h, required no transfer", mon_src, tx_data);
        end else begin
          mon_e = expq.pop_front();
          if (mon_src != mon_e.src || tx_data !== mon_e.dat || req_ready !== grant ||
              (mon_e.gap >= 0 && (cyc - last_xfer) != mon_e.gap)) begin
            n_err++;
            $display("FAIL xfer: got src %0d data %02h gap %0d ready %b, required src %0d data %02h gap %0d ready %b",
                     mon_src, tx_data, cyc - last_xfer, req_ready, mon_e.src, mon_e.dat, mon_e.gap, grant);
          end
        end
        last_xfer = cyc;
      end
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    q0.delete();
    q1.delete();
    expq.delete();
    lock_mode = '0;
    tx_ready  = 1'b0;
    stat_clr  = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    req_data  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string nm);
    int t;
    t = 0;
    while ((expq.size() != 0 || busy) && t < 600) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (expq.size() != 0 || busy) begin
      n_err++;
      $display("FAIL %s_drain: got %0d pending busy=%b, required 0 pending idle", nm, expq.size(), busy);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    int t;
    int base;
    logic [31:0] stat_exp;
    rst_n     = 1'b1;
    tx_ready  = 1'b0;
    stat_clr  = 1'b0;
    lock_mode = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_outputs", 32'({grant, busy, tx_valid, req_ready}), 32'h0);
    chk("rst_stats", stat_bytes, 32'h0);

    // T1: single byte from R0, grant one cycle after valid, then idle.
    do_reset();
    #2;
    q0.push_back(8'h41);
    exp_push(0, 8'h41, -1);
    tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t1_grant_latency", 32'({grant, req_valid}), 32'({2'b00, 2'b01}));
    @(negedge clk);
    chk("t1_granted", 32'({grant, busy, tx_valid, tx_data}), 32'({2'b01, 1'b1, 1'b1, 8'h41}));
    @(negedge clk);
    chk("t1_released", 32'({grant, busy}), 32'h0);
    wait_drain("t1");

    // T2: both continuously valid, no lock: strict alternation with one bubble.
    do_reset();
    #2;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(8'(8'h10 + i));
      q1.push_back(8'(8'h20 + i));
      exp_push(0, 8'(8'h10 + i), (i == 0) ? -1 : 2);
      exp_push(1, 8'(8'h20 + i), 2);
    end
    tx_ready = 1'b1;
    wait_drain("t2");

    // T3: R1 locked 20-byte message, R0 arrives a cycle later; forced release after 16 bytes.
    do_reset();
    #2;
    lock_mode = 2'b10;
    for (int i = 0; i < 20; i++) q1.push_back(8'(8'h80 + i));
    for (int i = 0; i < 16; i++) exp_push(1, 8'(8'h80 + i), (i == 0) ? -1 : 1);
    exp_push(0, 8'h55, 2);
    exp_push(1, 8'h90, 2);
    for (int i = 1; i < 4; i++) exp_push(1, 8'(8'h90 + i), 1);
    tx_ready = 1'b1;
    @(negedge clk);
    #2;
    q0.push_back(8'h55);
    wait_drain("t3");

    // T4: UART stalls for 10 cycles in the middle of a locked burst.
    do_reset();
    #2;
    lock_mode = 2'b01;
    for (int i = 0; i < 6; i++) q0.push_back(8'(8'hA0 + i));
    exp_push(0, 8'hA0, -1);
    exp_push(0, 8'hA1, 1);
    exp_push(0, 8'hA2, 11);
    for (int i = 3; i < 6; i++) exp_push(0, 8'(8'hA0 + i), 1);
    tx_ready = 1'b1;
    base = xfer_cnt;
    t = 0;
    while (xfer_cnt < base + 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1 tx_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("t4_stall", 32'({tx_valid, tx_data, grant, req_ready}), 32'({1'b1, 8'hA2, 2'b01, 2'b00}));
    end
    @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_drain("t4");

    // T5: async reset while R1 owns a stalled UART; R0 must win afterwards.
    do_reset();
    #2;
    q0.push_back(8'h30);
    exp_push(0, 8'h30, -1);
    tx_ready = 1'b1;
    wait_drain("t5_pre");
    tx_ready = 1'b0;
    q1.push_back(8'h31);
    t = 0;
    while (grant != 2'b10 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("t5_owned", 32'({grant, tx_valid}), 32'({2'b10, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_rst", 32'({grant, busy, tx_valid, req_ready}), 32'h0);
    do_reset();
    #2;
    q1.push_back(8'h32);
    q0.push_back(8'h33);
    exp_push(0, 8'h33, -1);
    exp_push(1, 8'h32, 2);
    tx_ready = 1'b1;
    wait_drain("t5");

    // T6: statistics count, clear, clear-beats-transfer, count again.
    do_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      q0.push_back(8'(8'h60 + i));
      exp_push(0, 8'(8'h60 + i), (i == 0) ? -1 : 2);
    end
    tx_ready = 1'b1;
    wait_drain("t6_send");
    @(negedge clk);
`ifdef UART_ARB_STATS_EN
    stat_exp = 32'h0000_0003;
`else
    stat_exp = 32'h0;
`endif
    chk("t6_count", stat_bytes, stat_exp);
    @(posedge clk);
    #1 stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    @(negedge clk);
    chk("t6_cleared", stat_bytes, 32'h0);
    #2;
    q0.push_back(8'h64);
    exp_push(0, 8'h64, -1);
    stat_clr = 1'b1;
    wait_drain("t6_clr_wins");
    @(negedge clk);
    stat_clr = 1'b0;
    @(negedge clk);
    chk("t6_clr_wins", stat_bytes, 32'h0);
    #2;
    q1.push_back(8'h65);
    exp_push(1, 8'h65, -1);
    wait_drain("t6_r1");
    @(negedge clk);
`ifdef UART_ARB_STATS_EN
    stat_exp = 32'h0001_0000;
`else
    stat_exp = 32'h0;
`endif
    chk("t6_count_r1", stat_bytes, stat_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
